// File: rtl/ram_pkg.sv
// Shared constants and types for the 32x4 scratch RAM.
// Contents: word/address widths, depth, address and data typedefs.
package ram_pkg;

  localparam int unsigned RAM_DATA_W = 4;
  localparam int unsigned RAM_ADDR_W = 5;
  localparam int unsigned RAM_DEPTH  = 32;

  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
  typedef logic [RAM_DATA_W-1:0] ram_data_t;

endpackage : ram_pkg

// File: rtl/ram.sv
// Single-port RAM: synchronous write, combinational (or optionally registered) read.
// Build option: define RAM_REG_OUT_EN to register dataout (1-cycle, read-first).
// Ports:
//   clk     - clock, writes on rising edge
//   rst_n   - asynchronous active-low reset, clears every word
//   we      - write enable
//   a       - shared read/write address
//   di      - write data
//   dataout - read data for address a
module ram
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = RAM_DATA_W,
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] dataout
);

  // Flop array: the async clear rules out SRAM macro mapping.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[a] <= di;
    end
  end

  assign rd_data = mem[a];

`ifdef RAM_REG_OUT_EN
  ram_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rd_data),
    .q    (dataout)
  );
`else
  // Zero-latency read straight from the array.
  assign dataout = rd_data;
`endif

endmodule : ram

// File: rtl/ram_out_reg.sv
// Optional read-data output register with asynchronous active-low clear.
// Ports:
//   clk   - clock, captures d on the rising edge
//   rst_n - asynchronous active-low clear
//   d     - combinational read data from the array
//   q     - registered read data
module ram_out_reg
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Output flop; d is sampled before the same-edge array write (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule : ram_out_reg

// File: rtl/ram_32x4.sv
// 32-word x 4-bit scratch RAM, top-level wrapper around ram.
// Build option: RAM_REG_OUT_EN selects the registered-output read path.
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   we      - write enable
//   a       - 5-bit address
//   di      - 4-bit write data
//   dataout - 4-bit read data
module ram_32x4
  import ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [RAM_ADDR_W-1:0] a,
  input  logic [RAM_DATA_W-1:0] di,
  output logic [RAM_DATA_W-1:0] dataout
);

  ram #(
    .DATA_W(RAM_DATA_W),
    .ADDR_W(RAM_ADDR_W),
    .DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .a      (a),
    .di     (di),
    .dataout(dataout)
  );

endmodule : ram_32x4

// File: tb/tb_ram_32x4.sv
// Self-checking bench for ram_32x4: directed scenarios plus random traffic,
// a word-array reference model and a queue-based scoreboard.
module tb_ram_32x4;

`ifdef RAM_REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we;
  logic [4:0] a;
  logic [3:0] di;
  logic [3:0] dataout;

  ram_32x4 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .a      (a),
    .di     (di),
    .dataout(dataout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    bit         chk;
    logic [3:0] exp;
    string      name;
  } ent_t;

  ent_t       q[$];
  logic [3:0] model[32];
  int         n_pass  = 0;
  int         n_total = 0;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: dataout=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 4'h0;
  endtask

  // One clock cycle of stimulus; the read result is queued for the monitor.
  task automatic cyc_op(input logic w, input logic [4:0] ad, input logic [3:0] d,
                        input bit chk, input string nm);
    ent_t e;
    @(posedge clk);
    #1;
    we = w; a = ad; di = d;
    e.due  = cyc + LAT;
    e.chk  = chk;
    e.exp  = model[ad];
    e.name = nm;
    q.push_back(e);
    if (w) model[ad] = d;
  endtask

  task automatic drain();
    int n = 0;
    we = 1'b0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: compare dataout at the negedge on which each entry falls due.
  always @(negedge clk) begin
    ent_t e;
    while (q.size() != 0 && q[0].due < cyc) begin
      e = q.pop_front();
      n_total++;
      $display("FAIL stale_%s: due=%0d now=%0d", e.name, e.due, cyc);
    end
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.chk) check(e.name, dataout, e.exp);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; we = 1'b0; a = '0; di = '0;
    clear_model();
    #3;
    check("reset_dout", dataout, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read
    cyc_op(1'b1, 5'd3, 4'd4, 1'b0, "w3");
    cyc_op(1'b1, 5'd7, 4'd8, 1'b0, "w7");
    cyc_op(1'b1, 5'd12, 4'd2, 1'b0, "w12");
    cyc_op(1'b0, 5'd3, 4'($urandom), 1'b1, "basic_r3");
    cyc_op(1'b0, 5'd7, 4'($urandom), 1'b1, "basic_r7");
    cyc_op(1'b0, 5'd12, 4'($urandom), 1'b1, "basic_r12");

    // Boundary addresses, then sweep to confirm nothing else moved
    cyc_op(1'b1, 5'd0, 4'd15, 1'b0, "w0");
    cyc_op(1'b1, 5'd31, 4'd10, 1'b0, "w31");
    for (int i = 0; i < 32; i++) cyc_op(1'b0, 5'(i), 4'($urandom), 1'b1, "bound_sweep");

    // Write-enable gating
    cyc_op(1'b1, 5'd20, 4'd6, 1'b0, "w20");
    for (int i = 0; i < 3; i++) cyc_op(1'b0, 5'd20, 4'd3, 1'b1, "we_gate");

    // Same-address write: old value shown on the write cycle, new one after
    cyc_op(1'b1, 5'd9, 4'd1, 1'b0, "w9");
    cyc_op(1'b0, 5'd9, 4'd0, 1'b1, "same_hold");
    cyc_op(1'b1, 5'd9, 4'd14, 1'b1, "same_pre");
    cyc_op(1'b0, 5'd9, 4'd0, 1'b1, "same_post");

    // Random traffic
    for (int i = 0; i < 300; i++)
      cyc_op(1'($urandom), 5'($urandom), 4'($urandom), 1'b1, "random");
    drain();

    // Reset clears memory, mid-cycle and without a clock edge
    for (int i = 0; i < 32; i++) cyc_op(1'b1, 5'(i), 4'(i), 1'b0, "fill");
    cyc_op(1'b0, 5'd13, 4'd0, 1'b1, "fill_r13");
    drain();
    @(posedge clk);
    #3;
    a = 5'd13;
    rst_n = 1'b0;
    clear_model();
    #1;
    check("reset_imm", dataout, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) cyc_op(1'b0, 5'(i), 4'($urandom), 1'b1, "reset_sweep");
    drain();

    // Reset during a write edge
    cyc_op(1'b1, 5'd5, 4'd7, 1'b0, "w5_pre");
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    we = 1'b1; a = 5'd5; di = 4'd9;
    clear_model();
    @(posedge clk);
    #1;
    check("rdw_held", dataout, 4'h0);
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    cyc_op(1'b0, 5'd5, 4'd0, 1'b1, "rdw_a5");
    cyc_op(1'b0, 5'd5, 4'd0, 1'b1, "rdw_a5_again");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ram_32x4
